// File: rtl/alu_serial.sv
// alu_serial -- bit-serial 32-bit ALU (AND, OR, ADD, COMPARE).
//
// A single 1-bit slice plus a carry register walks the operands LSB first,
// one bit per clock. One operation takes the accepting edge, 32 RUN edges
// and one FINISH edge; done_o is high for the cycle after the FINISH edge.
//
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous reset, active low
//   start_i      in   1   request, sampled only in IDLE
//   src1_i       in  32   operand A
//   src2_i       in  32   operand B
//   a_invert_i   in   1   invert A (ignored for COMPARE)
//   b_invert_i   in   1   invert B, also the carry-in (ignored for COMPARE)
//   operation_i  in   2   0 AND, 1 OR, 2 ADD, 3 COMPARE
//   bonus_op_i   in   3   compare select: 0 slt, 1 sgt, 2 sle, 3 sge,
//                         4 seq, 5 sne, 6/7 constant 0
//   busy_o       out  1   operation in progress
//   done_o       out  1   one-cycle completion pulse
//   result_o     out 32   registered result
//   cout_o       out  1   carry out of bit 31 (ADD only)
//   overflow_o   out  1   signed overflow (ADD only)
//   zero_o       out  1   result is zero
//
// Configuration macro: ALU_SERIAL_ZERO_EN
//   defined   -> zero_o is registered at FINISH as (result == 0)
//   undefined -> zero_o is tied to 0 and no zero-detect logic exists

module alu_serial (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        a_invert_i,
  input  logic        b_invert_i,
  input  logic [1:0]  operation_i,
  input  logic [2:0]  bonus_op_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        cout_o,
  output logic        overflow_o,
  output logic        zero_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_ADD = 2'd2;
  localparam logic [1:0] OP_CMP = 2'd3;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_sh_q, a_sh_d;
  logic [31:0] b_sh_q, b_sh_d;
  logic [31:0] res_sh_q, res_sh_d;
  logic        carry_q, carry_d;
  logic        c31_q, c31_d;
  logic [1:0]  op_q, op_d;
  logic [2:0]  bonus_q, bonus_d;
  logic        a_inv_q, a_inv_d;
  logic        b_inv_q, b_inv_d;
  logic [31:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  // One-bit slice operating on the current LSB of the shift registers.
  logic a_bit, b_bit, slice_bit, slice_carry;

  always_comb begin
    a_bit       = a_sh_q[0] ^ a_inv_q;
    b_bit       = b_sh_q[0] ^ b_inv_q;
    slice_carry = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    case (op_q)
      OP_AND:  slice_bit = a_bit & b_bit;
      OP_OR:   slice_bit = a_bit | b_bit;
      default: slice_bit = a_bit ^ b_bit ^ carry_q;
    endcase
  end

  // Final result and flags, evaluated from the completed serial pass.
  // Signed overflow is the carry into bit 31 differing from the carry out.
  logic [31:0] fin_result;
  logic        fin_cout, fin_ovf;
  logic        raw_ovf, less, equal, pred;

  always_comb begin
    raw_ovf = c31_q ^ carry_q;
    less    = res_sh_q[31] ^ raw_ovf;
    equal   = (res_sh_q == 32'd0);
    case (bonus_q)
      3'd0:    pred = less;
      3'd1:    pred = ~less & ~equal;
      3'd2:    pred = less | equal;
      3'd3:    pred = ~less;
      3'd4:    pred = equal;
      3'd5:    pred = ~equal;
      default: pred = 1'b0;
    endcase
    fin_result = res_sh_q;
    fin_cout   = 1'b0;
    fin_ovf    = 1'b0;
    case (op_q)
      OP_ADD: begin
        fin_cout = carry_q;
        fin_ovf  = raw_ovf;
      end
      OP_CMP: fin_result = {31'd0, pred};
      default: ;
    endcase
  end

  // Next-state logic. COMPARE forces A + ~B + 1 regardless of the invert
  // inputs; other ops use the invert inputs with b_invert_i as carry-in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    c31_d    = c31_q;
    op_d     = op_q;
    bonus_d  = bonus_q;
    a_inv_d  = a_inv_q;
    b_inv_d  = b_inv_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          a_sh_d   = src1_i;
          b_sh_d   = src2_i;
          res_sh_d = 32'd0;
          op_d     = operation_i;
          bonus_d  = bonus_op_i;
          cnt_d    = 5'd0;
          c31_d    = 1'b0;
          if (operation_i == OP_CMP) begin
            a_inv_d = 1'b0;
            b_inv_d = 1'b1;
            carry_d = 1'b1;
          end else begin
            a_inv_d = a_invert_i;
            b_inv_d = b_invert_i;
            carry_d = b_invert_i;
          end
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[31:1]};
        b_sh_d   = {1'b0, b_sh_q[31:1]};
        res_sh_d = {slice_bit, res_sh_q[31:1]};
        carry_d  = slice_carry;
        if (cnt_q == 5'd31) begin
          c31_d   = carry_q;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      FINISH: begin
        result_d = fin_result;
        cout_d   = fin_cout;
        ovf_d    = fin_ovf;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      a_sh_q   <= 32'd0;
      b_sh_q   <= 32'd0;
      res_sh_q <= 32'd0;
      carry_q  <= 1'b0;
      c31_q    <= 1'b0;
      op_q     <= 2'd0;
      bonus_q  <= 3'd0;
      a_inv_q  <= 1'b0;
      b_inv_q  <= 1'b0;
      result_q <= 32'd0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      c31_q    <= c31_d;
      op_q     <= op_d;
      bonus_q  <= bonus_d;
      a_inv_q  <= a_inv_d;
      b_inv_q  <= b_inv_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_SERIAL_ZERO_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (state_q == FINISH) begin
      zero_d = (fin_result == 32'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      zero_q <= 1'b0;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;
`else
  assign zero_o = 1'b0;
`endif

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign cout_o     = cout_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial -- scoreboard bench for alu_serial.
//
// The driver issues directed operations with hand-computed results and pushes
// each expectation (result, flags, cycle of done) into a queue. A monitor
// pops and compares whenever done_o is seen on a falling edge.

module tb_alu_serial;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] src1_i = 32'd0;
  logic [31:0] src2_i = 32'd0;
  logic        a_invert_i = 1'b0;
  logic        b_invert_i = 1'b0;
  logic [1:0]  operation_i = 2'd0;
  logic [2:0]  bonus_op_i = 3'd0;
  logic        busy_o, done_o, cout_o, overflow_o, zero_o;
  logic [31:0] result_o;

  alu_serial dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .a_invert_i  (a_invert_i),
    .b_invert_i  (b_invert_i),
    .operation_i (operation_i),
    .bonus_op_i  (bonus_op_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .result_o    (result_o),
    .cout_o      (cout_o),
    .overflow_o  (overflow_o),
    .zero_o      (zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    int          done_cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   n_issued = 0;

  function automatic logic zexp(logic [31:0] r);
`ifdef ALU_SERIAL_ZERO_EN
    return (r == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (rst_i && done_o) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL unexpected_done at cycle %0d: got done, required none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".result"}, result_o, e.res);
        check({e.name, ".cout"}, {31'd0, cout_o}, {31'd0, e.c});
        check({e.name, ".overflow"}, {31'd0, overflow_o}, {31'd0, e.v});
        check({e.name, ".zero"}, {31'd0, zero_o}, {31'd0, e.z});
        check({e.name, ".latency"}, cyc, e.done_cyc);
      end
    end
  end

  // Drive one request; the accepting edge is the next rising edge.
  task automatic applyStimulus(string name, logic [1:0] op, logic [2:0] bo,
                               logic [31:0] a, logic [31:0] b,
                               logic ai, logic bi,
                               logic [31:0] res, logic c, logic v);
    exp_t e;
    src1_i      = a;
    src2_i      = b;
    operation_i = op;
    bonus_op_i  = bo;
    a_invert_i  = ai;
    b_invert_i  = bi;
    start_i     = 1'b1;
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    e.res      = res;
    e.c        = c;
    e.v        = v;
    e.z        = zexp(res);
    e.done_cyc = cyc + 33;
    e.name     = name;
    exp_q.push_back(e);
    n_issued++;
    check({name, ".busy"}, {31'd0, busy_o}, 32'd1);
  endtask

  // Returns on the falling edge where done_o is seen, bounded.
  task automatic waitDone(string name);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_i);
      if (done_o) return;
    end
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s.timeout: got no done, required done within 60 cycles", name);
  endtask

  task automatic runOp(string name, logic [1:0] op, logic [2:0] bo,
                       logic [31:0] a, logic [31:0] b, logic ai, logic bi,
                       logic [31:0] res, logic c, logic v);
    applyStimulus(name, op, bo, a, b, ai, bi, res, c, v);
    waitDone(name);
    @(negedge clk_i);
  endtask

  task automatic checkOutput(string name, logic [31:0] res, logic c, logic v,
                             logic z, logic busy, logic done);
    check({name, ".result"}, result_o, res);
    check({name, ".cout"}, {31'd0, cout_o}, {31'd0, c});
    check({name, ".overflow"}, {31'd0, overflow_o}, {31'd0, v});
    check({name, ".zero"}, {31'd0, zero_o}, {31'd0, z});
    check({name, ".busy"}, {31'd0, busy_o}, {31'd0, busy});
    check({name, ".done"}, {31'd0, done_o}, {31'd0, done});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, required finish before 100000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    checkOutput("reset_state", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Arithmetic and logic vectors
    runOp("add_ovf",  2'd2, 3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    runOp("sub_eq",   2'd2, 3'd0, 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    runOp("add_wrap", 2'd2, 3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    runOp("or_ainv",  2'd1, 3'd0, 32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'hFFFF0001, 1'b0, 1'b0);
    runOp("and_plain",2'd0, 3'd0, 32'hDEADBEEF, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0E0D0E0F, 1'b0, 1'b0);

    // Compare vectors
    runOp("slt_m1_1", 2'd3, 3'd0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    runOp("sgt_m1_1", 2'd3, 3'd1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    runOp("c7_m1_1",  2'd3, 3'd7, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    runOp("sge_m1_1", 2'd3, 3'd3, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    runOp("sgt_1_m1", 2'd3, 3'd1, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    runOp("seq_eq",   2'd3, 3'd4, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    runOp("sne_eq",   2'd3, 3'd5, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    runOp("sle_eq",   2'd3, 3'd2, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
    runOp("seq_inv",  2'd3, 3'd4, 32'h00000007, 32'h00000007, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0);
    runOp("slt_ovf",  2'd3, 3'd0, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);

    // Start pulses while busy are ignored; result holds during RUN
    applyStimulus("and_busy", 2'd0, 3'd0, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 1'b0,
                  32'h0F0F0000, 1'b0, 1'b0);
    repeat (4) @(negedge clk_i);
    src1_i = 32'h11111111; src2_i = 32'h22222222; operation_i = 2'd2; start_i = 1'b1;
    check("hold_during_run.result", result_o, 32'h00000001);
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    waitDone("and_busy");
    repeat (3) @(negedge clk_i);
    check("single_done.count", n_done, n_issued);

    // Back-to-back: start held high while done is high
    applyStimulus("b2b_add", 2'd2, 3'd0, 32'h00000001, 32'h00000002, 1'b0, 1'b0,
                  32'h00000003, 1'b0, 1'b0);
    waitDone("b2b_add");
    applyStimulus("b2b_or", 2'd1, 3'd0, 32'h000000A0, 32'h00000005, 1'b0, 1'b0,
                  32'h000000A5, 1'b0, 1'b0);
    waitDone("b2b_or");
    @(negedge clk_i);

    // Reset mid-RUN abandons the operation
    applyStimulus("aborted", 2'd2, 3'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0,
                  32'h80000000, 1'b0, 1'b1);
    repeat (16) @(negedge clk_i);
    #2;
    rst_i = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    n_issued--;
    #1;
    checkOutput("mid_reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    repeat (40) @(negedge clk_i);
    check("no_done_after_reset.count", n_done, n_issued);

    runOp("and_restart", 2'd0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 1'b0,
          32'hF000F000, 1'b0, 1'b0);

    check("final.done_count", n_done, n_issued);
    check("final.queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
